// File: rtl/slot_scheduler.sv
// Per-slot TX/RX sequencer: decides each 625 us slot whether the radio transmits,
// listens or idles, and times out the RX search window when no sync is seen.
module slot_scheduler #(
  parameter logic [9:0] RX_WIN_US  = 10'd90,
  parameter logic [9:0] TX_LEAD_US = 10'd620
) (
  input  logic        clk_6M,
  input  logic        rst,
  input  logic        p_1us,
  input  logic        tslot_p,
  input  logic [9:0]  offcounter_1us,
  input  logic [27:0] BTCLK,
  input  logic        corre_sync_p,
  input  logic        rx_pktend_p,
  input  logic        conn_en,
  input  logic        is_master,
  input  logic        tx_req,
  input  logic [2:0]  tx_slots,
  output logic        tx_en,
  output logic        rx_en,
  output logic        tx_prep_p,
  output logic        tx_start_p,
  output logic        rx_timeout_p,
  output logic [2:0]  sched_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    TX      = 3'd2,
    RX_SRCH = 3'd3,
    RX_PKT  = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] slot_left_reg, slot_left_next;
  logic [2:0] tx_len_reg, tx_len_next;
  logic [2:0] tx_len;
  logic       tx_start_reg;
  logic       own_slot;
  logic       win_end;
  logic       lead_hit;
  logic       unused_btclk;

  // Only the slot-parity bit of the native clock matters here.
  assign unused_btclk = ^{BTCLK[27:2], BTCLK[0], tx_len_reg};

  // Upcoming slot is even when BTCLK[1] is set; master owns even, slave owns odd.
  assign own_slot = is_master ? BTCLK[1] : ~BTCLK[1];
  assign win_end  = p_1us && (offcounter_1us == RX_WIN_US);
  assign lead_hit = p_1us && (offcounter_1us == TX_LEAD_US);

  always_comb begin
    case (tx_slots)
      3'd3:    tx_len = 3'd3;
      3'd5:    tx_len = 3'd5;
      default: tx_len = 3'd1;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    slot_left_next = slot_left_reg;
    tx_len_next    = tx_len_reg;
    tx_prep_p      = 1'b0;
    rx_timeout_p   = 1'b0;
    if (!conn_en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = WAIT;
        WAIT, HOLD: begin
          if (state_reg == WAIT && lead_hit && own_slot && tx_req)
            tx_prep_p = 1'b1;
          if (tslot_p) begin
            if (own_slot && tx_req) begin
              state_next     = TX;
              tx_len_next    = tx_len;
              slot_left_next = tx_len - 3'd1;
            end else if (own_slot && is_master) begin
              state_next = WAIT;
            end else begin
              state_next = RX_SRCH;
            end
          end
        end
        TX: begin
          if (tslot_p) begin
            if (slot_left_reg != 3'd0)
              slot_left_next = slot_left_reg - 3'd1;
            else
              state_next = RX_SRCH;
          end
        end
        RX_SRCH: begin
          // A sync hit in the expiry cycle takes precedence over the timeout.
          if (corre_sync_p) begin
            state_next = RX_PKT;
          end else if (win_end) begin
            rx_timeout_p = 1'b1;
            state_next   = WAIT;
          end
        end
        RX_PKT: begin
          if (rx_pktend_p)
            state_next = HOLD;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_reg     <= IDLE;
      slot_left_reg <= 3'd0;
      tx_len_reg    <= 3'd0;
      tx_start_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slot_left_reg <= slot_left_next;
      tx_len_reg    <= tx_len_next;
      tx_start_reg  <= (state_next == TX) && (state_reg != TX);
    end
  end

  assign tx_en       = (state_reg == TX);
  assign rx_en       = (state_reg == RX_SRCH) || (state_reg == RX_PKT);
  assign tx_start_p  = tx_start_reg;
  assign sched_state = state_reg;

endmodule

// File: tb/tb_slot_scheduler.sv
// Self-checking bench for slot_scheduler: a slot-timing generator drives the
// schedule, a monitor logs output events, and each test compares them with expected events.
module tb_slot_scheduler;

  localparam int K_PREP  = 1;
  localparam int K_START = 2;
  localparam int K_TXON  = 3;
  localparam int K_TXOFF = 4;
  localparam int K_RXON  = 5;
  localparam int K_RXOFF = 6;
  localparam int K_TMO   = 7;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic        clk_6M;
  logic        rst;
  logic        p_1us;
  logic        tslot_p;
  logic [9:0]  offcounter_1us;
  logic [27:0] BTCLK;
  logic        corre_sync_p;
  logic        rx_pktend_p;
  logic        conn_en;
  logic        is_master;
  logic        tx_req;
  logic [2:0]  tx_slots;
  logic        tx_en;
  logic        rx_en;
  logic        tx_prep_p;
  logic        tx_start_p;
  logic        rx_timeout_p;
  logic [2:0]  sched_state;

  int   cyc;
  int   checks;
  int   errors;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic tx_en_q, rx_en_q, both_en_seen;

  slot_scheduler dut (
    .clk_6M         (clk_6M),
    .rst            (rst),
    .p_1us          (p_1us),
    .tslot_p        (tslot_p),
    .offcounter_1us (offcounter_1us),
    .BTCLK          (BTCLK),
    .corre_sync_p   (corre_sync_p),
    .rx_pktend_p    (rx_pktend_p),
    .conn_en        (conn_en),
    .is_master      (is_master),
    .tx_req         (tx_req),
    .tx_slots       (tx_slots),
    .tx_en          (tx_en),
    .rx_en          (rx_en),
    .tx_prep_p      (tx_prep_p),
    .tx_start_p     (tx_start_p),
    .rx_timeout_p   (rx_timeout_p),
    .sched_state    (sched_state)
  );

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  // Slot timing: one us every two clocks, 625 us per slot, BTCLK[1] = slot parity.
  task automatic drive_timing();
    int off, slot;
    off            = (cyc / 2) % 625;
    slot           = cyc / 1250;
    p_1us          = (cyc % 2) == 1;
    offcounter_1us = 10'(off);
    tslot_p        = p_1us && (off == 624);
    BTCLK          = {slot[26:0], (off >= 312)};
  endtask

  initial begin
    cyc = 0;
    drive_timing();
    forever begin
      @(posedge clk_6M);
      #1;
      cyc++;
      drive_timing();
    end
  end

  function automatic int t_edge(int s);
    return 1250 * s + 1249;
  endfunction

  function automatic int p_at(int s, int o);
    return 1250 * s + 2 * o + 1;
  endfunction

  function automatic string kname(int k);
    case (k)
      K_PREP:  return "prep";
      K_START: return "start";
      K_TXON:  return "tx_on";
      K_TXOFF: return "tx_off";
      K_RXON:  return "rx_on";
      K_RXOFF: return "rx_off";
      K_TMO:   return "timeout";
      default: return "none";
    endcase
  endfunction

  function automatic void push_obs(int k);
    ev_t e;
    e.kind = k;
    e.cyc  = cyc;
    obs_q.push_back(e);
  endfunction

  function automatic void expect_ev(int k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  initial begin
    tx_en_q      = 1'b0;
    rx_en_q      = 1'b0;
    both_en_seen = 1'b0;
  end

  always @(negedge clk_6M) begin
    if (tx_prep_p === 1'b1) push_obs(K_PREP);
    if (tx_start_p === 1'b1) push_obs(K_START);
    if (tx_en === 1'b1 && !tx_en_q) push_obs(K_TXON);
    if (tx_en === 1'b0 && tx_en_q) push_obs(K_TXOFF);
    if (rx_en === 1'b1 && !rx_en_q) push_obs(K_RXON);
    if (rx_en === 1'b0 && rx_en_q) push_obs(K_RXOFF);
    if (rx_timeout_p === 1'b1) push_obs(K_TMO);
    if (tx_en === 1'b1 && rx_en === 1'b1) both_en_seen = 1'b1;
    tx_en_q = (tx_en === 1'b1);
    rx_en_q = (rx_en === 1'b1);
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk_6M);
      #2;
    end
  endtask

  task automatic setup();
    conn_en      = 1'b0;
    tx_req       = 1'b0;
    tx_slots     = 3'd1;
    corre_sync_p = 1'b0;
    rx_pktend_p  = 1'b0;
    goto(cyc + 3);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_and_check(input string name, input int deadline);
    ev_t o, e;
    while (obs_q.size() < exp_q.size() && cyc < deadline) begin
      @(negedge clk_6M);
      #1;
    end
    if (obs_q.size() < exp_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d events, expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s_%s: got nothing, expected %s@%0d", name, kname(e.kind), kname(e.kind), e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.cyc !== e.cyc) begin
          errors++;
          $display("FAIL %s_%s: got %s@%0d, expected %s@%0d", name, kname(e.kind),
                   kname(o.kind), o.cyc, kname(e.kind), e.cyc);
        end
      end
    end
    $display("%s: events checked at cycle %0d", name, cyc);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    conn_en      = 1'b1;
    is_master    = 1'b1;
    tx_req       = 1'b0;
    tx_slots     = 3'd1;
    corre_sync_p = 1'b0;
    rx_pktend_p  = 1'b0;
    goto(4);
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d, expected 0", sched_state); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL rst_tx_en: got %b, expected 0", tx_en); end
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL rst_rx_en: got %b, expected 0", rx_en); end
    checks++; if (tx_start_p !== 1'b0) begin errors++; $display("FAIL rst_start: got %b, expected 0", tx_start_p); end
    checks++; if (tx_prep_p !== 1'b0) begin errors++; $display("FAIL rst_prep: got %b, expected 0", tx_prep_p); end
    checks++; if (rx_timeout_p !== 1'b0) begin errors++; $display("FAIL rst_tmo: got %b, expected 0", rx_timeout_p); end
    rst = 1'b0;
    goto(5);
    checks++; if (sched_state !== 3'd1) begin errors++; $display("FAIL rst_to_wait: got %0d, expected 1", sched_state); end
    conn_en = 1'b0;
    goto(6);
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL conn_off_idle: got %0d, expected 0", sched_state); end
    $display("reset: state and outputs checked at cycle %0d", cyc);
  endtask

  // Master TX of len slots starting in the even slot after odd slot s.
  task automatic test_master_tx(input int len_code, input int len);
    int    s;
    string name;
    name = $sformatf("master_tx%0d", len_code);
    setup();
    is_master = 1'b1;
    tx_req    = 1'b1;
    tx_slots  = 3'(len_code);
    s = cyc / 1250 + 1;
    if (s % 2 == 0) s++;
    goto(1250 * s + 10);
    conn_en = 1'b1;
    expect_ev(K_PREP,  p_at(s, 620));
    expect_ev(K_START, t_edge(s) + 1);
    expect_ev(K_TXON,  t_edge(s) + 1);
    expect_ev(K_TXOFF, t_edge(s + len) + 1);
    expect_ev(K_RXON,  t_edge(s + len) + 1);
    expect_ev(K_TMO,   p_at(s + len + 1, 90));
    expect_ev(K_RXOFF, p_at(s + len + 1, 90) + 1);
    goto(t_edge(s) + 3);
    checks++; if (sched_state !== 3'd2) begin errors++; $display("FAIL %s_in_tx: got %0d, expected 2", name, sched_state); end
    // Changes after entry must not alter the packet in flight.
    tx_req   = 1'b0;
    tx_slots = 3'd5;
    run_and_check(name, p_at(s + len + 1, 90) + 50);
    checks++; if (sched_state !== 3'd1) begin errors++; $display("FAIL %s_end_wait: got %0d, expected 1", name, sched_state); end
  endtask

  task automatic test_slave_timeout();
    int s;
    setup();
    is_master = 1'b0;
    s = cyc / 1250 + 1;
    goto(1250 * s + 10);
    conn_en = 1'b1;
    expect_ev(K_RXON,  t_edge(s) + 1);
    expect_ev(K_TMO,   p_at(s + 1, 90));
    expect_ev(K_RXOFF, p_at(s + 1, 90) + 1);
    run_and_check("slave_timeout", p_at(s + 1, 90) + 50);
    checks++; if (sched_state !== 3'd1) begin errors++; $display("FAIL slave_timeout_wait: got %0d, expected 1", sched_state); end
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL slave_timeout_rx_en: got %b, expected 0", rx_en); end
  endtask

  task automatic test_slave_rx_then_tx();
    int s, e;
    setup();
    is_master = 1'b0;
    s = cyc / 1250 + 1;
    if (s % 2 == 0) s++;
    e = p_at(s + 3, 100);
    goto(1250 * s + 10);
    conn_en = 1'b1;
    expect_ev(K_RXON,  t_edge(s) + 1);
    expect_ev(K_RXOFF, e + 1);
    expect_ev(K_START, t_edge(s + 3) + 1);
    expect_ev(K_TXON,  t_edge(s + 3) + 1);
    expect_ev(K_TXOFF, t_edge(s + 4) + 1);
    expect_ev(K_RXON,  t_edge(s + 4) + 1);
    goto(p_at(s + 1, 68));
    corre_sync_p = 1'b1;
    goto(p_at(s + 1, 68) + 1);
    corre_sync_p = 1'b0;
    goto(t_edge(s + 1) + 3);
    checks++; if (sched_state !== 3'd4) begin errors++; $display("FAIL rxpkt_slot1: got %0d, expected 4", sched_state); end
    goto(t_edge(s + 2) + 3);
    checks++; if (sched_state !== 3'd4) begin errors++; $display("FAIL rxpkt_slot2: got %0d, expected 4", sched_state); end
    tx_req   = 1'b1;
    tx_slots = 3'd2;
    goto(e);
    rx_pktend_p = 1'b1;
    goto(e + 1);
    rx_pktend_p = 1'b0;
    checks++; if (sched_state !== 3'd5) begin errors++; $display("FAIL hold_state: got %0d, expected 5", sched_state); end
    goto(t_edge(s + 3) + 3);
    tx_req = 1'b0;
    run_and_check("slave_rx_tx", t_edge(s + 4) + 50);
    checks++; if (sched_state !== 3'd3) begin errors++; $display("FAIL slave_tx_end: got %0d, expected 3", sched_state); end
  endtask

  task automatic test_sync_at_expiry();
    int s, p;
    setup();
    is_master = 1'b0;
    s = cyc / 1250 + 1;
    p = p_at(s + 1, 90);
    goto(1250 * s + 10);
    conn_en = 1'b1;
    expect_ev(K_RXON, t_edge(s) + 1);
    goto(p);
    corre_sync_p = 1'b1;
    goto(p + 1);
    corre_sync_p = 1'b0;
    checks++; if (sched_state !== 3'd4) begin errors++; $display("FAIL coinc_state: got %0d, expected 4", sched_state); end
    checks++; if (rx_en !== 1'b1) begin errors++; $display("FAIL coinc_rx_en: got %b, expected 1", rx_en); end
    run_and_check("coinc", p + 50);
    goto(p + 10);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL coinc_extra: got %0d extra events, expected 0", obs_q.size()); end
  endtask

  task automatic test_abort();
    int s, x, d;
    // Reset in the middle of a 5-slot transmission.
    setup();
    is_master = 1'b1;
    tx_req    = 1'b1;
    tx_slots  = 3'd5;
    s = cyc / 1250 + 1;
    if (s % 2 == 0) s++;
    x = t_edge(s + 2) + 10;
    goto(1250 * s + 10);
    conn_en = 1'b1;
    expect_ev(K_PREP,  p_at(s, 620));
    expect_ev(K_START, t_edge(s) + 1);
    expect_ev(K_TXON,  t_edge(s) + 1);
    expect_ev(K_TXOFF, x + 1);
    goto(t_edge(s) + 3);
    tx_req = 1'b0;
    goto(x);
    rst = 1'b1;
    goto(x + 1);
    rst = 1'b0;
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL rst_mid_tx_state: got %0d, expected 0", sched_state); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_en: got %b, expected 0", tx_en); end
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_en: got %b, expected 0", rx_en); end
    conn_en = 1'b0;
    run_and_check("rst_mid_tx", x + 50);
    // Link drop in the middle of a packet reception.
    setup();
    is_master = 1'b0;
    s = cyc / 1250 + 1;
    d = p_at(s + 1, 200);
    goto(1250 * s + 10);
    conn_en = 1'b1;
    expect_ev(K_RXON,  t_edge(s) + 1);
    expect_ev(K_RXOFF, d + 1);
    goto(p_at(s + 1, 68));
    corre_sync_p = 1'b1;
    goto(p_at(s + 1, 68) + 1);
    corre_sync_p = 1'b0;
    goto(d);
    conn_en = 1'b0;
    goto(d + 1);
    checks++; if (sched_state !== 3'd0) begin errors++; $display("FAIL conn_drop_state: got %0d, expected 0", sched_state); end
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL conn_drop_rx_en: got %b, expected 0", rx_en); end
    run_and_check("conn_drop", d + 50);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_master_tx(1, 1);
    test_master_tx(3, 3);
    test_master_tx(5, 5);
    test_slave_timeout();
    test_slave_rx_then_tx();
    test_sync_at_expiry();
    test_abort();
    checks++;
    if (both_en_seen) begin
      errors++;
      $display("FAIL tx_rx_exclusive: got both enables high, expected never");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
